// File: rtl/gamepad_pkg.sv
// Purpose: shared types and constants for the serial gamepad reader.
// Latency: n/a (definitions only).
// Backpressure: n/a; the reader has no flow control, it polls at a fixed rate.
package gamepad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_CLK_LO,
        ST_CLK_HI,
        ST_GAP
    } pad_state_t;

    // NES button positions within a frame (bit index = shift order)
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchronizer for asynchronous pad data.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
// Ports: clk, rst_n (sync, active-low), d (async in), q (synchronized out).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gamepad_reader.sv
// Purpose: polls NES/SNES-style serial pads (shared latch/pad_clk) and publishes button state.
// Latency: buttons/pressed/released/frame_valid update on the first GAP cycle after the last bit.
// Backpressure: none; results are strobes, a consumer must take them on frame_valid.
// Ports: clk, rst_n (sync, active-low), enable, data[NUM_PADS] (active-low serial),
//        latch, pad_clk, buttons/pressed/released[NUM_PADS*NUM_BITS] (pad p at [p*NUM_BITS +: NUM_BITS]),
//        frame_valid, frame_count[16].
module gamepad_reader
    import gamepad_pkg::*;
#(
    parameter int NUM_PADS    = 2,
    parameter int NUM_BITS    = 8,
    parameter int HALF_PERIOD = 256,
    parameter int GAP_CYCLES  = 131072
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [NUM_PADS-1:0]          data,
    output logic                         latch,
    output logic                         pad_clk,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed,
    output logic [NUM_PADS*NUM_BITS-1:0] released,
    output logic                         frame_valid,
    output logic [15:0]                  frame_count
);

    localparam int PH_W  = $clog2(2 * HALF_PERIOD);
    localparam int IDX_W = $clog2(NUM_BITS);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [PH_W-1:0]  PH_LATCH_LAST = PH_W'(2 * HALF_PERIOD - 1);
    localparam logic [PH_W-1:0]  PH_HALF_LAST  = PH_W'(HALF_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(NUM_BITS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST      = GAP_W'(GAP_CYCLES - 1);

    pad_state_t                   state;
    logic [PH_W-1:0]              phase;
    logic [IDX_W-1:0]             bit_idx;
    logic [GAP_W-1:0]             gap_cnt;
    logic [NUM_PADS-1:0]          data_sync;
    logic [NUM_PADS*NUM_BITS-1:0] sample;
    logic [NUM_PADS*NUM_BITS-1:0] sample_next;

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_sync
        sync_2ff #(.WIDTH(1)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (data[p]),
            .q     (data_sync[p])
        );
    end

    // Current sample vector with the bit under the cursor replaced by live pad data.
    // Captured on the last cycle of LATCH (bit 0) and of each CLK_HI (bits 1..N-1).
    always_comb begin
        sample_next = sample;
        for (int p = 0; p < NUM_PADS; p++) begin
            sample_next[p*NUM_BITS + int'(bit_idx)] = data_sync[p];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            phase       <= '0;
            bit_idx     <= '0;
            gap_cnt     <= '0;
            sample      <= '0;
            latch       <= 1'b0;
            pad_clk     <= 1'b0;
            buttons     <= '0;
            pressed     <= '0;
            released    <= '0;
            frame_valid <= 1'b0;
            frame_count <= '0;
        end else begin
            pressed     <= '0;
            released    <= '0;
            frame_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state   <= ST_LATCH;
                        latch   <= 1'b1;
                        phase   <= '0;
                        bit_idx <= '0;
                    end
                end

                ST_LATCH: begin
                    if (phase == PH_LATCH_LAST) begin
                        sample  <= sample_next;
                        latch   <= 1'b0;
                        phase   <= '0;
                        bit_idx <= IDX_W'(1);
                        state   <= ST_CLK_LO;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                ST_CLK_LO: begin
                    if (phase == PH_HALF_LAST) begin
                        pad_clk <= 1'b1;
                        phase   <= '0;
                        state   <= ST_CLK_HI;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                ST_CLK_HI: begin
                    if (phase == PH_HALF_LAST) begin
                        sample  <= sample_next;
                        pad_clk <= 1'b0;
                        phase   <= '0;
                        if (bit_idx == IDX_LAST) begin
                            // Pads are active-low: a 0 on the wire is a pressed button.
                            buttons     <= ~sample_next;
                            pressed     <= ~sample_next & ~buttons;
                            released    <= buttons & sample_next;
                            frame_valid <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                            gap_cnt     <= '0;
                            state       <= ST_GAP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            state   <= ST_CLK_LO;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (enable) begin
                            state   <= ST_LATCH;
                            latch   <= 1'b1;
                            phase   <= '0;
                            bit_idx <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    latch   <= 1'b0;
                    pad_clk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gamepad_reader.sv
// Purpose: randomized self-checking bench for gamepad_reader against a frame-level pad model.
// Latency: n/a.
// Backpressure: n/a.
module tb_gamepad_reader;

    localparam int NP  = 2;
    localparam int NB  = 8;
    localparam int HP  = 4;
    localparam int GAP = 16;
    localparam int W   = NP * NB;
    localparam int FRAME_CYC = 2*HP + (NB-1)*2*HP + GAP;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [NP-1:0] data;
    logic          latch;
    logic          pad_clk;
    logic [W-1:0]  buttons;
    logic [W-1:0]  pressed;
    logic [W-1:0]  released;
    logic          frame_valid;
    logic [15:0]   frame_count;

    int total = 0;
    int bad   = 0;

    // Wire-level bits each pad will shift out next frame (active-low), pad p at [p*NB +: NB].
    logic [W-1:0]  pad_bits;
    logic [NP-1:0][NB-1:0] shreg;

    // Reference model state
    logic [W-1:0]  exp_btn;
    logic [15:0]   exp_cnt;

    always #5 clk = ~clk;

    gamepad_reader #(
        .NUM_PADS    (NP),
        .NUM_BITS    (NB),
        .HALF_PERIOD (HP),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .data        (data),
        .latch       (latch),
        .pad_clk     (pad_clk),
        .buttons     (buttons),
        .pressed     (pressed),
        .released    (released),
        .frame_valid (frame_valid),
        .frame_count (frame_count)
    );

    // Behavioural 4021-style pad: parallel load on latch, shift toward bit 0 on pad_clk rise.
    always @(posedge pad_clk or posedge latch) begin
        for (int p = 0; p < NP; p++) begin
            if (latch) shreg[p] <= pad_bits[p*NB +: NB];
            else       shreg[p] <= {1'b1, shreg[p][NB-1:1]};
        end
    end

    always_comb begin
        data = '0;
        for (int p = 0; p < NP; p++) data[p] = shreg[p][0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs until frame_valid is seen (sampled on negedge), collecting waveform statistics.
    task automatic wait_frame(input int drop_at_pulse,
                              output int cycles, output int latch_cyc, output int pulses,
                              output int hi_cyc, output int stray, output bit timed_out);
        logic prev_clk = 1'b0;
        cycles = 0; latch_cyc = 0; pulses = 0; hi_cyc = 0; stray = 0; timed_out = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cycles++;
            if (latch) latch_cyc++;
            if (pad_clk) hi_cyc++;
            if (pad_clk && !prev_clk) pulses++;
            prev_clk = pad_clk;
            if (drop_at_pulse != 0 && pulses == drop_at_pulse && pad_clk) enable = 1'b0;
            if (frame_valid) begin
                timed_out = 1'b0;
                break;
            end
            if (pressed != '0 || released != '0) stray++;
        end
    endtask

    // Frame-level expectation: new buttons are the inverted wire bits; edges vs previous state.
    task automatic check_frame(input string tag);
        logic [W-1:0] nb;
        nb = ~pad_bits;
        check({tag, "_btn"},  32'(buttons),  32'(nb));
        check({tag, "_prs"},  32'(pressed),  32'(nb & ~exp_btn));
        check({tag, "_rel"},  32'(released), 32'(exp_btn & ~nb));
        exp_btn = nb;
        exp_cnt = exp_cnt + 16'd1;
        check({tag, "_cnt"},  32'(frame_count), 32'(exp_cnt));
    endtask

    initial begin
        int  cyc, lc, pc, hc, st;
        bit  to;
        int  seen;

        rst_n    = 1'b0;
        enable   = 1'b0;
        pad_bits = '1;
        exp_btn  = '0;
        exp_cnt  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_latch", 32'(latch), 0);
        check("rst_padclk", 32'(pad_clk), 0);
        check("rst_btn", 32'(buttons), 0);
        check("rst_fv", 32'(frame_valid), 0);
        check("rst_cnt", 32'(frame_count), 0);

        // Frame 1: pad 0 presses A only
        pad_bits = {8'hFF, 8'hFE};
        enable = 1'b1;
        rst_n  = 1'b1;
        wait_frame(0, cyc, lc, pc, hc, st, to);
        check("f1_timeout", 32'(to), 0);
        check("f1_latch_len", 32'(lc), 32'(2*HP));
        check("f1_pulses", 32'(pc), 32'(NB-1));
        check("f1_hi_cyc", 32'(hc), 32'((NB-1)*HP));
        check("f1_stray", 32'(st), 0);
        check_frame("f1");
        @(negedge clk);
        check("f1_fv_once", 32'(frame_valid), 0);
        check("f1_prs_once", 32'(pressed), 0);

        // Frame 2: A released
        pad_bits = '1;
        wait_frame(0, cyc, lc, pc, hc, st, to);
        check("f2_timeout", 32'(to), 0);
        check("f2_period", 32'(cyc + 1), 32'(FRAME_CYC));
        check_frame("f2");

        // Randomized frames
        for (int f = 0; f < 12; f++) begin
            pad_bits = W'($urandom);
            wait_frame(0, cyc, lc, pc, hc, st, to);
            check("rnd_timeout", 32'(to), 0);
            check("rnd_period", 32'(cyc), 32'(FRAME_CYC));
            check("rnd_pulses", 32'(pc), 32'(NB-1));
            check("rnd_stray", 32'(st), 0);
            check_frame("rnd");
        end

        // Enable drops during the high phase of pulse 3: frame still completes
        pad_bits = W'($urandom);
        wait_frame(3, cyc, lc, pc, hc, st, to);
        check("drop_timeout", 32'(to), 0);
        check("drop_pulses", 32'(pc), 32'(NB-1));
        check_frame("drop");
        seen = 0;
        for (int i = 0; i < 3*FRAME_CYC; i++) begin
            @(negedge clk);
            if (latch || frame_valid) seen++;
        end
        check("idle_quiet", 32'(seen), 0);

        // Reset during LATCH discards the frame
        enable = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && !latch; i++) @(negedge clk);
        check("rl_latch_seen", 32'(latch), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rl_latch", 32'(latch), 0);
        check("rl_btn", 32'(buttons), 0);
        check("rl_cnt", 32'(frame_count), 0);
        enable = 1'b0;
        for (int i = 0; i < 2*FRAME_CYC; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (frame_valid || pressed != '0 || released != '0) seen++;
        end
        check("rl_no_fv", 32'(seen), 0);
        exp_btn = '0;

        // frame_count wraps from 0xFFFF
        force dut.frame_count = 16'hFFFF;
        #1;
        release dut.frame_count;
        exp_cnt  = 16'hFFFF;
        pad_bits = W'($urandom);
        enable   = 1'b1;
        wait_frame(0, cyc, lc, pc, hc, st, to);
        check("wrap_timeout", 32'(to), 0);
        check_frame("wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
